register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised multi-read-port register file with write-through bypass and a per-register pending-write
//  scoreboard. Sits in the CPU datapath between decode (read/issue) and writeback (write). Flags RAW hazards
//  to the hazard/stall unit instead of relying on a split-edge write.
// PARAMETERS
//  DATA_W    64  register / bus width in bits
//  ADDR_W    5   register index width; DEPTH = 2**ADDR_W
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_IDX  31  index hard-wired to zero (reads 0, writes and issues ignored)
//  BYPASS    1   1: a same-cycle write is forwarded to a matching read; 0: the read returns the stored value
// PORTS
//  Clk       in   1               clock, rising edge
//  Reset     in   1               asynchronous reset, active-high
//  RA        in   NUM_RD*ADDR_W   packed read indices; port i = RA[i*ADDR_W +: ADDR_W]
//  RdEn      in   NUM_RD          read-port i in use (qualifies hazard check)
//  Bus       out  NUM_RD*DATA_W   packed read data, combinational
//  RdBusy    out  NUM_RD          read-port i targets a pending register
//  Stall     out  1               |(RdEn & RdBusy)
//  IssueV    in   1               instruction issued with destination IssueRd
//  IssueRd   in   ADDR_W          destination to mark pending
//  RegWr     in   1               writeback strobe
//  RW        in   ADDR_W          writeback index
//  BusW      in   DATA_W          writeback data
//  PendCnt   out  ADDR_W+1        number of registers currently pending
// BEHAVIOUR
//  - Reset (async, Reset=1): all registers <= 0, all pending bits <= 0, PendCnt <= 0.
//    Outputs while in reset: Bus=0, RdBusy=0, Stall=0.
//  - Write: on rising Clk edge with RegWr=1 and RW!=ZERO_IDX, reg[RW] <= BusW and pending[RW] <= 0 (unless re-issued, below).
//  - Read: combinational, zero latency.
//    Bus_i = 0 if RA_i==ZERO_IDX;
//    else BusW if BYPASS && RegWr && RW==RA_i;
//    else reg[RA_i].
//  - Pending: on a rising edge with IssueV=1 and IssueRd!=ZERO_IDX, pending[IssueRd] <= 1.
//  - Simultaneous issue and writeback, same index: issue wins, so the pending bit stays 1 (a newer producer is in flight).
//    Data is still written.
//  - RdBusy_i = pending[RA_i] && !(RegWr && RW==RA_i && BYPASS); always 0 for ZERO_IDX.
//    A register being written this cycle, with BYPASS=1, is not busy.
//  - Writeback to a non-pending register is legal: data is written and pending is unaffected.
//  - Issue to an already-pending register is legal: the bit stays 1 and PendCnt is unchanged.
//  - PendCnt is a registered up/down counter tracking the popcount of the pending bits. Per edge, with set/clear taken
//    from the rules above (including the ZERO_IDX exclusion and issue-wins):
//    +1 if a clear bit is set; -1 if a set bit is cleared; both events on different indices -> net 0.
//    It never wraps; max = DEPTH-1, since ZERO_IDX is excluded.
//  - Multiple read ports may address the same index; each gets identical data and busy.
//  - Reset asserted mid-operation overrides any same-cycle write or issue.
// STRUCTURE
//  - regfile_pkg: constants for the default DATA_W / ADDR_W / ZERO_IDX, plus a function for packed-slice extraction.
//  - Sub-module regfile_scoreboard: pending bit vector, set/clear priority, PendCnt counter, and busy lookup per port.
//    The top level holds the storage array, bypass muxes and zero-index masking.
//  - Read ports are built with a generate loop over NUM_RD; there is no per-port duplicated code.
// TESTING
//  1. Reset=1 mid-run, then release -> every port reads 0, RdBusy=0, PendCnt=0; write 0xDEAD to R3, then RA0=3 -> Bus0=0xDEAD.
//  2. RegWr=1, RW=5, BusW=0x1234 with RA1=5 in the same cycle -> Bus1=0x1234 before the edge (BYPASS=1);
//     rebuild with BYPASS=0 -> Bus1 shows the old value until after the edge.
//  3. Write 0xFFFF to ZERO_IDX=31 and IssueRd=31 -> reads of 31 return 0; PendCnt stays 0; RdBusy never set for 31.
//  4. Issue R7; next cycle RA0=7, RdEn0=1 -> RdBusy0=1, Stall=1, PendCnt=1; writeback R7 -> same cycle RdBusy0=0, Stall=0;
//     after the edge PendCnt=0.
//  5. Same edge: IssueRd=9 and RegWr with RW=9 while R9 is pending -> data written, pending[9] stays 1, PendCnt unchanged.
//  6. Same edge: issue R2 (clear) and writeback R4 (pending) -> PendCnt unchanged; then issue R1..R30 and R0 ->
//     PendCnt=31, with no wrap.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the register file and a helper that locates a port's
// slice inside a packed multi-port bus.
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_ZERO_IDX = 31;

  // Low bit of element idx in a packed vector of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register set at issue and cleared at
// writeback, a running count of pending registers, and busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = DEF_ZERO_IDX,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  input  logic                     issue_v_i,
  input  logic [ADDR_W-1:0]        issue_rd_i,
  input  logic                     reg_wr_i,
  input  logic [ADDR_W-1:0]        rw_i,
  output logic [NUM_RD-1:0]        busy_o,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX  = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_ok, clr_ok, inc, dec;

  always_comb begin
    set_ok = issue_v_i && (issue_rd_i != ZIDX);
    clr_ok = reg_wr_i && (rw_i != ZIDX);
    // Set is applied after clear so a same-index issue keeps the bit high.
    pend_d = pend_q;
    if (clr_ok) pend_d[rw_i] = 1'b0;
    if (set_ok) pend_d[issue_rd_i] = 1'b1;
    inc   = set_ok && !pend_q[issue_rd_i];
    dec   = clr_ok && pend_q[rw_i] && !(set_ok && (issue_rd_i == rw_i));
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + ONE;
    else if (dec && !inc) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt_o = cnt_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    localparam int ALO = slice_lo(g, ADDR_W);
    logic [ADDR_W-1:0] ra;
    logic              wr_hit;

    assign ra          = ra_i[ALO +: ADDR_W];
    assign wr_hit      = (BYPASS != 0) && reg_wr_i && (rw_i == ra);
    assign busy_o[g]   = (ra != ZIDX) && pend_q[ra] && !wr_hit;
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with write-through bypass, a hard-wired zero
// register, and a pending-write scoreboard that reports RAW hazards as Stall.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = DEF_ZERO_IDX,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  input  logic [NUM_RD-1:0]        RdEn,
  output logic [NUM_RD*DATA_W-1:0] Bus,
  output logic [NUM_RD-1:0]        RdBusy,
  output logic                     Stall,
  input  logic                     IssueV,
  input  logic [ADDR_W-1:0]        IssueRd,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        BusW,
  output logic [ADDR_W:0]          PendCnt
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX  = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [NUM_RD-1:0] busy;
  logic              wr_ok;

  assign wr_ok = RegWr && (RW != ZIDX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[RW] <= BusW;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_IDX(ZERO_IDX),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .ra_i      (RA),
    .issue_v_i (IssueV),
    .issue_rd_i(IssueRd),
    .reg_wr_i  (RegWr),
    .rw_i      (RW),
    .busy_o    (busy),
    .pend_cnt_o(PendCnt)
  );

  // Outputs are forced quiet while Reset is held, even if BusW is being driven.
  assign RdBusy = busy & ~{NUM_RD{Reset}};
  assign Stall  = |(RdEn & RdBusy);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    localparam int ALO = slice_lo(g, ADDR_W);
    localparam int DLO = slice_lo(g, DATA_W);
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;

    assign ra = RA[ALO +: ADDR_W];

    always_comb begin
      rdata = regs_q[ra];
      if (Reset || (ra == ZIDX))                        rdata = '0;
      else if ((BYPASS != 0) && RegWr && (RW == ra))    rdata = BusW;
    end

    assign Bus[DLO +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Randomized and directed bench for register_file_sb; two instances (bypass on
// and off) are checked every cycle against an array-based reference model.
module tb_register_file_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int ZI = 31;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [NR*AW-1:0] RA;
  logic [NR-1:0]  RdEn;
  logic           IssueV;
  logic [AW-1:0]  IssueRd;
  logic           RegWr;
  logic [AW-1:0]  RW;
  logic [DW-1:0]  BusW;

  logic [NR*DW-1:0] Bus_b, Bus_n;
  logic [NR-1:0]    RdBusy_b, RdBusy_n;
  logic             Stall_b, Stall_n;
  logic [AW:0]      PendCnt_b, PendCnt_n;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mreg  [32];
  bit            mpend [32];

  always #5 Clk = ~Clk;

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_IDX(ZI), .BYPASS(1)) u_byp (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RdEn(RdEn), .Bus(Bus_b), .RdBusy(RdBusy_b),
    .Stall(Stall_b), .IssueV(IssueV), .IssueRd(IssueRd), .RegWr(RegWr), .RW(RW),
    .BusW(BusW), .PendCnt(PendCnt_b));

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_IDX(ZI), .BYPASS(0)) u_nob (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RdEn(RdEn), .Bus(Bus_n), .RdBusy(RdBusy_n),
    .Stall(Stall_n), .IssueV(IssueV), .IssueRd(IssueRd), .RegWr(RegWr), .RW(RW),
    .BusW(BusW), .PendCnt(PendCnt_n));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: storage array plus a set of pending indices.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = '0;
        mpend[i] = 1'b0;
      end
    end else begin
      if (RegWr && RW != ZI) begin
        mreg[RW]  = BusW;
        mpend[RW] = 1'b0;
      end
      if (IssueV && IssueRd != ZI) mpend[IssueRd] = 1'b1;
    end
  end

  function automatic logic [AW-1:0] port_addr(input int p);
    logic [NR*AW-1:0] v;
    v = RA;
    return v[p*AW +: AW];
  endfunction

  function automatic logic [63:0] m_bus(input int p, input bit byp);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (Reset || a == ZI) return '0;
    if (byp && RegWr && RW == a) return BusW;
    return mreg[a];
  endfunction

  function automatic bit m_busy(input int p, input bit byp);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (Reset || a == ZI) return 1'b0;
    return mpend[a] && !(byp && RegWr && RW == a);
  endfunction

  function automatic int m_cnt();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(mpend[i]);
    return c;
  endfunction

  always @(negedge Clk) begin
    logic [NR-1:0] eb, en;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("bus_byp%0d", p), Bus_b[p*DW +: DW], m_bus(p, 1'b1));
      chk($sformatf("bus_nob%0d", p), Bus_n[p*DW +: DW], m_bus(p, 1'b0));
      eb[p] = m_busy(p, 1'b1);
      en[p] = m_busy(p, 1'b0);
    end
    chk("busy_byp", 64'(RdBusy_b), 64'(eb));
    chk("busy_nob", 64'(RdBusy_n), 64'(en));
    chk("stall_byp", 64'(Stall_b), 64'(|(RdEn & eb)));
    chk("stall_nob", 64'(Stall_n), 64'(|(RdEn & en)));
    chk("cnt_byp", 64'(PendCnt_b), 64'(m_cnt()));
    chk("cnt_nob", 64'(PendCnt_n), 64'(m_cnt()));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    IssueV  = 1'b0;
    IssueRd = '0;
    RegWr   = 1'b0;
    RW      = '0;
    BusW    = '0;
  endtask

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 31));
    if ($urandom_range(0, 4) == 0) return AW'(ZI);
    return AW'($urandom_range(0, 3));
  endfunction

  task automatic rnd_cycle(input bit allow_rst);
    Reset   = allow_rst && ($urandom_range(0, 79) == 0);
    RA      = {rnd_idx(), rnd_idx()};
    RdEn    = NR'($urandom_range(0, 3));
    IssueV  = ($urandom_range(0, 2) == 0);
    IssueRd = rnd_idx();
    RegWr   = ($urandom_range(0, 1) == 1);
    RW      = rnd_idx();
    BusW    = {$urandom, $urandom};
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    RA    = '0;
    RdEn  = '0;
    idle();
    repeat (2) tick();
    chk("rst_cnt", 64'(PendCnt_b), 64'd0);
    Reset = 1'b0;

    // Reset asserted in the middle of activity overrides a same-cycle write/issue.
    repeat (20) rnd_cycle(1'b0);
    Reset = 1'b1; RegWr = 1'b1; RW = 5'd3; BusW = 64'h55; IssueV = 1'b1; IssueRd = 5'd3;
    RA = {5'd3, 5'd3}; RdEn = 2'b11;
    #3;
    chk("t1_bus_in_rst", Bus_b[63:0], 64'd0);
    chk("t1_busy_in_rst", 64'(RdBusy_b), 64'd0);
    chk("t1_cnt_in_rst", 64'(PendCnt_b), 64'd0);
    tick();
    Reset = 1'b0; idle(); RdEn = '0;
    tick();
    chk("t1_r3_after_rst", Bus_b[63:0], 64'd0);
    RegWr = 1'b1; RW = 5'd3; BusW = 64'hDEAD;
    tick();
    idle(); RA = {5'd0, 5'd3};
    #3;
    chk("t1_dead", Bus_b[63:0], 64'hDEAD);
    tick();

    // Same-cycle write is forwarded only when bypass is enabled.
    RegWr = 1'b1; RW = 5'd5; BusW = 64'h1111;
    tick();
    RegWr = 1'b1; RW = 5'd5; BusW = 64'h1234; RA = {5'd5, 5'd0};
    #3;
    chk("t2_byp", Bus_b[127:64], 64'h1234);
    chk("t2_nob_old", Bus_n[127:64], 64'h1111);
    tick();
    idle();
    #3;
    chk("t2_nob_new", Bus_n[127:64], 64'h1234);
    tick();

    // Zero register ignores writes and issues.
    RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF; IssueV = 1'b1; IssueRd = 5'd31;
    RA = {5'd31, 5'd31}; RdEn = 2'b11;
    #3;
    chk("t3_bus0", Bus_b[63:0], 64'd0);
    chk("t3_bus1", Bus_b[127:64], 64'd0);
    chk("t3_busy", 64'(RdBusy_b), 64'd0);
    tick();
    idle();
    #3;
    chk("t3_cnt", 64'(PendCnt_b), 64'd0);
    chk("t3_bus_after", Bus_n[63:0], 64'd0);
    tick();

    // RAW hazard on R7, cleared combinationally by the writeback.
    IssueV = 1'b1; IssueRd = 5'd7; RdEn = 2'b00;
    tick();
    idle(); RA = {5'd0, 5'd7}; RdEn = 2'b01;
    #3;
    chk("t4_busy", 64'(RdBusy_b[0]), 64'd1);
    chk("t4_stall", 64'(Stall_b), 64'd1);
    chk("t4_cnt1", 64'(PendCnt_b), 64'd1);
    tick();
    RegWr = 1'b1; RW = 5'd7; BusW = 64'h77;
    #3;
    chk("t4_busy_wb", 64'(RdBusy_b[0]), 64'd0);
    chk("t4_stall_wb", 64'(Stall_b), 64'd0);
    chk("t4_nob_busy_wb", 64'(RdBusy_n[0]), 64'd1);
    chk("t4_fwd", Bus_b[63:0], 64'h77);
    tick();
    idle();
    #3;
    chk("t4_cnt0", 64'(PendCnt_b), 64'd0);
    tick();

    // Issue and writeback of the same pending register: issue wins, data lands.
    IssueV = 1'b1; IssueRd = 5'd9;
    tick();
    IssueV = 1'b1; IssueRd = 5'd9; RegWr = 1'b1; RW = 5'd9; BusW = 64'h99;
    #3;
    chk("t5_cnt_pre", 64'(PendCnt_b), 64'd1);
    tick();
    idle(); RA = {5'd0, 5'd9};
    #3;
    chk("t5_data", Bus_b[63:0], 64'h99);
    chk("t5_busy", 64'(RdBusy_b), 64'd1);
    chk("t5_cnt", 64'(PendCnt_b), 64'd1);
    tick();

    // Set and clear on different indices net to zero; fill all 31 usable bits.
    IssueV = 1'b1; IssueRd = 5'd4;
    tick();
    IssueV = 1'b1; IssueRd = 5'd2; RegWr = 1'b1; RW = 5'd4; BusW = 64'h44;
    tick();
    idle();
    #3;
    chk("t6_net0", 64'(PendCnt_b), 64'd2);
    tick();
    for (int i = 1; i <= 31; i++) begin
      IssueV = 1'b1; IssueRd = AW'(i % 31);
      tick();
    end
    idle();
    #3;
    chk("t6_full", 64'(PendCnt_b), 64'd31);
    IssueV = 1'b1; IssueRd = 5'd31;
    tick();
    idle();
    #3;
    chk("t6_nowrap", 64'(PendCnt_b), 64'd31);
    tick();

    repeat (800) rnd_cycle(1'b1);
    Reset = 1'b0;
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
